// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, registered result and flags out.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic [2:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   zero;
    logic                   carry;
    logic                   dz;
    logic                   err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, carry, dz, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, carry, dz, err
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shift-add multiply and restoring divide.
// Outputs are registered and only change on completion or reset.
module seq_alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int unsigned RW   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpMul = 3'b010;
    localparam logic [2:0] OpDiv = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpOr  = 3'b101;
    localparam logic [2:0] OpXor = 3'b110;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_mul_q, is_mul_d;
    logic [RW-1:0]     acc_q, acc_d;     // mul: partial product; div: {remainder, quotient}
    logic [RW-1:0]     x_q, x_d;         // shifted multiplicand
    logic [WIDTH-1:0]  y_q, y_d;         // mul: multiplier; div: divisor
    logic [RW-1:0]     result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              dz_q, dz_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              fin;
    logic [RW-1:0]     res_v;
    logic              carry_v, dz_v, err_v;
    logic [WIDTH:0]    sum, diff, rem_sh;
    logic              ge;
    logic [WIDTH-1:0]  rem_new;
    logic [RW-1:0]     acc_step;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dz_d     = dz_q;
        err_d    = err_q;
        done_d   = 1'b0;
        fin      = 1'b0;
        res_v    = '0;
        carry_v  = 1'b0;
        dz_v     = 1'b0;
        err_v    = 1'b0;
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        rem_sh   = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, y_q});
        rem_new  = ge ? WIDTH'(rem_sh - {1'b0, y_q}) : rem_sh[WIDTH-1:0];
        acc_step = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    fin = 1'b1;
                    case (bus.op)
                        OpAdd: begin
                            res_v   = RW'(sum);
                            carry_v = sum[WIDTH];
                        end
                        OpSub: begin
                            res_v   = RW'(diff);
                            carry_v = diff[WIDTH];
                        end
                        OpMul: begin
                            fin      = 1'b0;
                            state_d  = StRun;
                            is_mul_d = 1'b1;
                            cnt_d    = '0;
                            acc_d    = '0;
                            x_d      = RW'(bus.a);
                            y_d      = bus.b;
                        end
                        OpDiv: begin
                            if (bus.b == '0) begin
                                res_v = {bus.a, {WIDTH{1'b1}}};
                                dz_v  = 1'b1;
                            end else begin
                                fin      = 1'b0;
                                state_d  = StRun;
                                is_mul_d = 1'b0;
                                cnt_d    = '0;
                                acc_d    = RW'(bus.a);
                                y_d      = bus.b;
                            end
                        end
                        OpAnd:   res_v = RW'(bus.a & bus.b);
                        OpOr:    res_v = RW'(bus.a | bus.b);
                        OpXor:   res_v = RW'(bus.a ^ bus.b);
                        default: err_v = 1'b1;
                    endcase
                end
            end
            StRun: begin
                if (is_mul_q) begin
                    acc_step = acc_q + (y_q[0] ? x_q : '0);
                    x_d      = x_q << 1;
                    y_d      = y_q >> 1;
                end else begin
                    // Shift next dividend bit into the remainder, set quotient bit if it fits
                    acc_step = {rem_new, acc_q[WIDTH-2:0], ge};
                end
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    fin     = 1'b1;
                    res_v   = acc_step;
                end
            end
        endcase

        if (fin) begin
            result_d = res_v;
            zero_d   = (res_v == '0);
            carry_d  = carry_v;
            dz_d     = dz_v;
            err_d    = err_v;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == StRun);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;
    assign bus.dz     = dz_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized checks of seq_alu (WIDTH=4) against an arithmetic reference model.
module tb_seq_alu;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int last_res = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int op, input int a, input int b,
                         output int res, output bit cy, output bit dz, output bit er);
        int m;
        m  = 1 << W;
        cy = 1'b0;
        dz = 1'b0;
        er = 1'b0;
        case (op)
            0: begin res = a + b; cy = (a + b) >= m; end
            1: begin cy = a < b; res = ((a - b + m) % m) + (cy ? m : 0); end
            2: res = a * b;
            3: begin
                if (b == 0) begin res = a * m + (m - 1); dz = 1'b1; end
                else res = (a % b) * m + a / b;
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            default: begin res = 0; er = 1'b1; end
        endcase
    endtask

    // Drives one request starting now; returns at the sample where done is seen (or budget expires).
    task automatic do_op(input int op, input int a, input int b, input bit poke);
        int res, lat, busy_n, exp_lat, exp_busy;
        bit cy, dz, er, iter;
        model(op, a, b, res, cy, dz, er);
        iter     = (op == 2) || (op == 3 && b != 0);
        exp_lat  = iter ? W + 1 : 1;
        exp_busy = iter ? W : 0;
        bus.start = 1'b1;
        bus.op    = 3'(op);
        bus.a     = W'(a);
        bus.b     = W'(b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat <= 3 * W) begin
            if (bus.busy) busy_n++;
            if (poke && lat == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'b000;
                bus.a     = '1;
                bus.b     = '1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        chk($sformatf("done op%0d %0d,%0d", op, a, b), 32'(bus.done), 32'd1);
        chk($sformatf("latency op%0d %0d,%0d", op, a, b), 32'(lat), 32'(exp_lat));
        chk($sformatf("busy_cycles op%0d", op), 32'(busy_n), 32'(exp_busy));
        chk($sformatf("busy_at_done op%0d", op), 32'(bus.busy), 32'd0);
        chk($sformatf("result op%0d %0d,%0d", op, a, b), 32'(bus.result), 32'(res));
        chk($sformatf("zero op%0d %0d,%0d", op, a, b), 32'(bus.zero), 32'(res == 0));
        chk($sformatf("carry op%0d %0d,%0d", op, a, b), 32'(bus.carry), 32'(cy));
        chk($sformatf("dz op%0d %0d,%0d", op, a, b), 32'(bus.dz), 32'(dz));
        chk($sformatf("err op%0d %0d,%0d", op, a, b), 32'(bus.err), 32'(er));
        last_res = res;
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("hold_done", 32'(bus.done), 32'd0);
            chk("hold_result", 32'(bus.result), 32'(last_res));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},   32'(bus.busy),   32'd0);
        chk({tag, " done"},   32'(bus.done),   32'd0);
        chk({tag, " result"}, 32'(bus.result), 32'd0);
        chk({tag, " zero"},   32'(bus.zero),   32'd0);
        chk({tag, " carry"},  32'(bus.carry),  32'd0);
        chk({tag, " dz"},     32'(bus.dz),     32'd0);
        chk({tag, " err"},    32'(bus.err),    32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 15, 15, 1'b0);
        idle_hold(1);
        do_op(1, 3, 5, 1'b0);
        do_op(1, 5, 5, 1'b0);
        idle_hold(1);
        do_op(2, 15, 15, 1'b1);
        idle_hold(3);
        do_op(3, 13, 4, 1'b0);
        do_op(3, 9, 0, 1'b0);
        do_op(7, 6, 2, 1'b0);
        do_op(6, 10, 5, 1'b0);
        idle_hold(2);

        // Reset in the second busy cycle of a multiply
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("mid_mul busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            chk("post_reset no_done", 32'(bus.done), 32'd0);
        end
        do_op(2, 2, 3, 1'b0);

        for (int i = 0; i < 60; i++) begin
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_hold(int'($urandom_range(1, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised successor to the team's 4-bit registered ALU. Operands are latched on a start/busy/done handshake. Add, sub and logic ops complete in one cycle; multiply (shift-add) and divide (restoring) are iterative and take WIDTH cycles. The block adds status flags, defined divide-by-zero behaviour and a reserved-opcode error, and sits behind the top-level pin wrapper, which maps ui_in/uio_in onto its ports.

Parameters:
WIDTH, 4, operand width in bits; result width is 2*WIDTH; must be >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted when start=1 and busy=0 at a rising edge
op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 reserved
a  input  WIDTH  operand A, sampled only on accept
b  input  WIDTH  operand B, sampled only on accept
busy  output  1  high while an iterative op is running
done  output  1  one-cycle pulse; result and flags are valid from this cycle on
result  output  2*WIDTH  registered result, held until the next completion
zero  output  1  result == 0 (all 2*WIDTH bits), registered with result
carry  output  1  add: carry-out; sub: borrow (a<b); 0 for all other ops
dz  output  1  divide by zero occurred (op=div, b=0)
err  output  1  reserved opcode accepted

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy, done, result, zero, carry, dz, err all 0; iteration counter and internal registers cleared. Reset overrides an in-flight operation; no done is produced for it.
- States: IDLE, RUN.
- Accept: rising edge with start=1 and busy=0 (IDLE). a, b and op are latched. start while busy=1 is ignored, with no effect on the running op.
- Single-cycle ops (add, sub, and, or, xor, reserved, div with b=0): accept at edge k; result, flags and done=1 appear after edge k, i.e. latency 1. State stays IDLE and busy stays 0.
- Iterative ops (mul, div with b!=0): accept at edge k -> RUN, busy=1 from edge k through edge k+WIDTH-1. Exactly WIDTH iteration edges. After edge k+WIDTH: busy=0, done=1, result/flags updated, state=IDLE.
- done is high for exactly one cycle per accepted op. A start in the done cycle is accepted (back-to-back allowed, busy=0 then).
- Result formats, upper bits zero-filled:
  - add: {0.., carry, a+b[WIDTH-1:0]}, i.e. result = a+b in WIDTH+1 bits.
  - sub: result[WIDTH-1:0]=(a-b) mod 2^WIDTH, result[WIDTH]=borrow, rest 0.
  - and/or/xor: low WIDTH bits, rest 0.
  - mul: full 2*WIDTH unsigned product.
  - div: result[WIDTH-1:0]=quotient, result[2*WIDTH-1:WIDTH]=remainder.
  - div by zero: quotient all ones, remainder=a, dz=1; latency 1.
  - reserved: result=0, err=1, zero=1.
- carry, dz and err are cleared on every completion where they do not apply. All outputs update only on completion or reset; between completions they hold their values.
- Operands are unsigned. No combinational path from inputs to outputs.

Test Plan:
WIDTH=4 throughout.
- Add 15+15, start for 1 cycle -> next cycle done=1, result=0x1E, carry=1, zero=0, busy never asserted.
- Sub 3-5 -> result=0x1E (diff 0xE, borrow bit 4), carry=1. Then sub 5-5 -> result=0x00, zero=1, carry=0.
- Mul 15*15 -> busy=1 for 4 cycles, done in cycle 5 after accept, result=0xE1. Start pulsed with op=add during busy -> ignored, exactly one done observed.
- Div 13/4 -> after 4 busy cycles result=0x13 (rem 1, quot 3), dz=0. Div 9/0 -> latency 1, result=0x9F, dz=1, busy=0.
- op=111 -> result=0x00, err=1, zero=1. Back-to-back: xor 0xA^0x5 started in the done cycle -> next cycle result=0x0F, err=0.
- Reset mid-mul: assert rst_n=0 at the 2nd busy cycle -> all outputs 0 next edge, no done; a new mul 2*3 after release -> result=0x06.
